// File: rtl/adder_tree_pkg.sv
// Sizing helpers shared by the pipelined adder tree, its interface and bench.
//   tree_levels(length)             : binary reduction levels, $clog2(length)
//   stage_count(levels, per_stage)  : registered tree stages, at least one
//   level_length(length, level)     : element count entering a given level
package adder_tree_pkg;

  function automatic int tree_levels(input int length);
    int levels;
    levels = 0;
    while ((1 << levels) < length) levels++;
    return levels;
  endfunction

  // A zero-level tree (LENGTH=1) still gets one register so latency stays S+1.
  function automatic int stage_count(input int levels, input int levels_per_stage);
    if (levels == 0) return 1;
    return (levels + levels_per_stage - 1) / levels_per_stage;
  endfunction

  function automatic int level_length(input int length, input int level);
    int n;
    n = length;
    for (int l = 0; l < level; l++) n = (n + 1) / 2;
    return n;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree_if.sv
// Beat/frame-sum bus of the pipelined adder tree.
//   in_valid, in_last, in_addends : beat from the multiplier array
//   out_valid, out_sum            : frame sum pulse towards the activation stage
// master drives beats, slave (the tree) returns frame sums.
interface pipelined_adder_tree_if
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 42,
  parameter int ACC_GUARD  = 8
);
  localparam int OUT_WIDTH = DATA_WIDTH + tree_levels(LENGTH) + ACC_GUARD;

  logic                         in_valid;
  logic                         in_last;
  logic signed [DATA_WIDTH-1:0] in_addends [LENGTH];
  logic                         out_valid;
  logic signed [OUT_WIDTH-1:0]  out_sum;

  modport master (output in_valid, in_last, in_addends, input out_valid, out_sum);
  modport slave  (input in_valid, in_last, in_addends, output out_valid, out_sum);
endinterface

// File: rtl/adder_tree_level.sv
// One combinational reduction level of the adder tree.
//   in_data  : IN_LENGTH signed elements of IN_WIDTH bits
//   out_data : ceil(IN_LENGTH/2) signed elements of IN_WIDTH+1 bits
// Pairs (2i, 2i+1) are summed one bit wider, so no level can overflow; an odd
// trailing element is only sign-extended.
module adder_tree_level #(
  parameter int IN_LENGTH = 2,
  parameter int IN_WIDTH  = 8
) (
  input  logic signed [IN_WIDTH-1:0] in_data  [IN_LENGTH],
  output logic signed [IN_WIDTH:0]   out_data [(IN_LENGTH + 1) / 2]
);

  for (genvar i = 0; i < IN_LENGTH / 2; i++) begin : g_pair
    assign out_data[i] = {in_data[2*i][IN_WIDTH-1], in_data[2*i]}
                       + {in_data[2*i+1][IN_WIDTH-1], in_data[2*i+1]};
  end

  if (IN_LENGTH % 2 == 1) begin : g_odd
    assign out_data[IN_LENGTH/2] = {in_data[IN_LENGTH-1][IN_WIDTH-1], in_data[IN_LENGTH-1]};
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined, frame-accumulating adder tree.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pipelined_adder_tree_if (beats in, frame sums out)
// Each beat is reduced by a binary tree registered every LEVELS_PER_STAGE levels
// (S stages); tree results are then summed over the beats of a frame ending at
// in_last. out_valid pulses S+1 cycles after the last beat; out_sum holds.
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int LENGTH           = 42,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int ACC_GUARD        = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_adder_tree_if.slave bus
);

  localparam int LEVELS     = tree_levels(LENGTH);
  localparam int STAGES     = stage_count(LEVELS, LEVELS_PER_STAGE);
  localparam int TREE_WIDTH = DATA_WIDTH + LEVELS;
  localparam int OUT_WIDTH  = TREE_WIDTH + ACC_GUARD;

  logic signed [TREE_WIDTH-1:0] tree_sum;

  if (LEVELS == 0) begin : g_pass
    logic signed [DATA_WIDTH-1:0] data_q;
    // NOTE: tree data registers carry no reset; the reset valid chain alone
    // decides whether their contents are ever consumed.
    always_ff @(posedge clk) data_q <= bus.in_addends[0];
    assign tree_sum = data_q;
  end else begin : g_tree
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int IN_LEN = level_length(LENGTH, l);
      localparam int IN_W   = DATA_WIDTH + l;
      // Register after every LEVELS_PER_STAGE levels and always after the last.
      localparam bit REG    = ((l + 1) % LEVELS_PER_STAGE == 0) || (l == LEVELS - 1);

      logic signed [IN_W-1:0] lvl_in  [IN_LEN];
      logic signed [IN_W:0]   sum_c   [(IN_LEN + 1) / 2];
      logic signed [IN_W:0]   lvl_out [(IN_LEN + 1) / 2];

      if (l == 0) begin : g_src
        assign lvl_in = bus.in_addends;
      end else begin : g_src
        assign lvl_in = g_lvl[l-1].lvl_out;
      end

      adder_tree_level #(.IN_LENGTH(IN_LEN), .IN_WIDTH(IN_W)) u_level (
        .in_data  (lvl_in),
        .out_data (sum_c)
      );

      if (REG) begin : g_reg
        always_ff @(posedge clk) lvl_out <= sum_c;
      end else begin : g_comb
        assign lvl_out = sum_c;
      end
    end
    assign tree_sum = g_lvl[LEVELS-1].lvl_out[0];
  end

  // Valid/last travel beside the tree data; last is qualified so an idle
  // cycle with in_last=1 has no effect.
  logic [STAGES-1:0] valid_pipe;
  logic [STAGES-1:0] last_pipe;

  // NOTE: control state uses non-blocking assignments under an asynchronous
  // reset so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      valid_pipe[0] <= bus.in_valid;
      last_pipe[0]  <= bus.in_valid & bus.in_last;
      for (int k = 1; k < STAGES; k++) begin
        valid_pipe[k] <= valid_pipe[k-1];
        last_pipe[k]  <= last_pipe[k-1];
      end
    end
  end

  logic                        tree_valid;
  logic                        tree_last;
  logic signed [OUT_WIDTH-1:0] tree_ext;
  logic signed [OUT_WIDTH-1:0] acc;
  logic signed [OUT_WIDTH-1:0] acc_next;
  logic                        first;

  assign tree_valid = valid_pipe[STAGES-1];
  assign tree_last  = last_pipe[STAGES-1];
  assign tree_ext   = OUT_WIDTH'(tree_sum);
  // first discards the previous frame's total instead of clearing acc, so a
  // new frame may start on the cycle right after a last beat. Wraps silently.
  assign acc_next   = (first ? '0 : acc) + tree_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      first         <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
    end else begin
      bus.out_valid <= tree_valid & tree_last;
      if (tree_valid) begin
        acc   <= acc_next;
        first <= tree_last;
        if (tree_last) bus.out_sum <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree. Three instances:
//   dut0 : defaults (LENGTH=42, LEVELS_PER_STAGE=2, S=3, OUT_WIDTH=22)
//   dut1 : LENGTH=2, ACC_GUARD=0 (S=1, OUT_WIDTH=9, wrap case)
//   dut2 : LENGTH=1, LEVELS_PER_STAGE=1 (S=1, OUT_WIDTH=16)
// The reference model keeps a plain integer frame total per instance and
// schedules each expected frame sum at (beat cycle + S + 1); every cycle the
// monitor compares out_valid and the held out_sum against it.
module tb_pipelined_adder_tree;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipelined_adder_tree_if #(.DATA_WIDTH(8), .LENGTH(42), .ACC_GUARD(8)) bus_a ();
  pipelined_adder_tree_if #(.DATA_WIDTH(8), .LENGTH(2),  .ACC_GUARD(0)) bus_b ();
  pipelined_adder_tree_if #(.DATA_WIDTH(8), .LENGTH(1),  .ACC_GUARD(8)) bus_c ();

  pipelined_adder_tree #(.DATA_WIDTH(8), .LENGTH(42), .LEVELS_PER_STAGE(2), .ACC_GUARD(8))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  pipelined_adder_tree #(.DATA_WIDTH(8), .LENGTH(2), .LEVELS_PER_STAGE(2), .ACC_GUARD(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  pipelined_adder_tree #(.DATA_WIDTH(8), .LENGTH(1), .LEVELS_PER_STAGE(1), .ACC_GUARD(8))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  typedef struct {
    int     dut;
    longint cyc;
    longint sum;
  } exp_t;

  int     lat   [3] = '{3, 1, 1};
  int     w_out [3] = '{22, 9, 16};
  longint run_sum [3];
  longint held    [3];
  exp_t   exp_q [$];
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  int va [42];
  int vb [2];
  int vc [1];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  // Per-cycle comparison of one instance against the scheduled expectations.
  task automatic mon(input int dut, input logic v, input longint s);
    int idx;
    bit ev;
    idx = -1;
    ev  = 1'b0;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].dut == dut) idx = i;
    if (idx >= 0 && exp_q[idx].cyc == cyc) begin
      ev        = 1'b1;
      held[dut] = exp_q[idx].sum;
      exp_q.delete(idx);
    end
    check($sformatf("dut%0d out_valid @%0d", dut, cyc), longint'(v), longint'(ev));
    check($sformatf("dut%0d out_sum @%0d", dut, cyc), s, held[dut]);
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.out_valid, longint'(bus_a.out_sum));
    mon(1, bus_b.out_valid, longint'(bus_b.out_sum));
    mon(2, bus_c.out_valid, longint'(bus_c.out_sum));
  end

  // Advance to just after the next rising edge; all instances default to idle.
  task automatic next();
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_last = 1'b0;
  endtask

  // Apply the prepared addends of one instance this cycle and update the model.
  task automatic put(input int dut, input bit valid, input bit last);
    longint s;
    exp_t e;
    s = 0;
    case (dut)
      0: begin
        bus_a.in_valid = valid; bus_a.in_last = last;
        for (int i = 0; i < 42; i++) begin bus_a.in_addends[i] = 8'(va[i]); s += va[i]; end
      end
      1: begin
        bus_b.in_valid = valid; bus_b.in_last = last;
        for (int i = 0; i < 2; i++) begin bus_b.in_addends[i] = 8'(vb[i]); s += vb[i]; end
      end
      default: begin
        bus_c.in_valid = valid; bus_c.in_last = last;
        bus_c.in_addends[0] = 8'(vc[0]); s += vc[0];
      end
    endcase
    if (valid) begin
      run_sum[dut] += s;
      if (last) begin
        e.dut = dut;
        e.cyc = cyc + lat[dut] + 1;
        e.sum = wrap(run_sum[dut], w_out[dut]);
        exp_q.push_back(e);
        run_sum[dut] = 0;
      end
    end
  endtask

  // First n addends of instance 0 set to v, the rest zero.
  task automatic fill_a(input int v, input int n);
    for (int i = 0; i < 42; i++) va[i] = (i < n) ? v : 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int d = 0; d < 3; d++) begin
      run_sum[d] = 0;
      held[d]    = 0;
    end
  endtask

  initial begin
    model_reset();
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_last = 1'b0;
    fill_a(0, 0);
    vb = '{0, 0};
    vc = '{0};
    for (int i = 0; i < 42; i++) bus_a.in_addends[i] = '0;
    for (int i = 0; i < 2; i++) bus_b.in_addends[i] = '0;
    bus_c.in_addends[0] = '0;
    #1 rst_n = 1'b0;
    repeat (3) next();
    rst_n = 1'b1;
    next();

    // Single beats: +1, -128, +127 on the big tree; two-beat wrap frame on
    // dut1; a lone beat of 5 on the zero-level tree.
    next(); fill_a(1, 42);    put(0, 1, 1); vb = '{127, 127}; put(1, 1, 0); vc = '{5}; put(2, 1, 1);
    next(); fill_a(-128, 42); put(0, 1, 1); put(1, 1, 1);
    next(); fill_a(127, 42);  put(0, 1, 1);
    repeat (6) next();

    // Three-beat frame with an idle gap (in_last=1 while idle is ignored).
    next(); fill_a(1, 42);  put(0, 1, 0);
    next(); fill_a(2, 42);  put(0, 1, 0);
    next(); bus_a.in_last = 1'b1;
    next(); fill_a(-1, 42); put(0, 1, 1);
    repeat (8) next();

    // Back-to-back single-beat frames: 10, -20, 30.
    next(); fill_a(1, 10);  put(0, 1, 1);
    next(); fill_a(-1, 20); put(0, 1, 1);
    next(); fill_a(1, 30);  put(0, 1, 1);
    repeat (6) next();

    // Reset in the middle of a frame, then a fresh single-beat frame.
    next(); fill_a(3, 42); put(0, 1, 0); vb = '{50, 60}; put(1, 1, 0); vc = '{7}; put(2, 1, 0);
    next(); put(0, 1, 0); put(1, 1, 0); put(2, 1, 0);
    next(); rst_n = 1'b0; model_reset();
    next(); rst_n = 1'b1;
    next(); fill_a(1, 42); put(0, 1, 1);
    repeat (8) next();

    // Random beats, gaps and frame lengths on all instances.
    repeat (400) begin
      next();
      for (int i = 0; i < 42; i++) va[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 2; i++)  vb[i] = int'($urandom_range(0, 255)) - 128;
      vc[0] = int'($urandom_range(0, 255)) - 128;
      for (int d = 0; d < 3; d++)
        put(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end
    repeat (8) next();

    check("drain expectations left", longint'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_tree.md
# pipelined_adder_tree

Pipelined, frame-accumulating successor to the combinational adder tree. It reduces LENGTH signed addends per beat through a registered binary tree, then accumulates tree results across the beats of a frame delimited by in_last. It sits between the per-channel multiplier array and the activation stage, where the combinational tree no longer closes timing and dot products span several beats.

## Interface
- DATA_WIDTH, 8, signed width of each addend
- LENGTH, 42, addends per beat (≥1)
- LEVELS_PER_STAGE, 2, tree levels between pipeline registers (≥1)
- ACC_GUARD, 8, extra accumulator bits beyond tree width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present this cycle
- in_last  in  1  final beat of frame; ignored when in_valid=0
- in_addends  in  LENGTH×DATA_WIDTH  signed unpacked array
- out_valid  out  1  one-cycle pulse, frame sum valid
- out_sum  out  OUT_WIDTH  signed frame sum; holds until next frame completes

## Operation
- LEVELS = $clog2(LENGTH); TREE_WIDTH = DATA_WIDTH + LEVELS; OUT_WIDTH = TREE_WIDTH + ACC_GUARD.
- S = max(1, ceil(LEVELS / LEVELS_PER_STAGE)) tree pipeline stages; last stage always registered.
- Each level pairs elements 2i and 2i+1, sums at width+1, sign-extended; odd trailing element passes through sign-extended. Tree sum is exact (no overflow possible).
- in_valid and in_last travel with data through all S stages in a reset valid/last shift chain.
- Accumulator stage, on tree-valid: acc_next = (first ? 0 : acc) + sext(tree_sum); acc <= acc_next; first <= tree_last.
- On tree-valid with tree_last: out_sum <= acc_next, out_valid <= 1 next cycle; otherwise out_valid <= 0.
- Accumulator arithmetic wraps modulo 2^OUT_WIDTH two's complement; no saturation, no overflow flag.
- No backpressure: one beat accepted per cycle, unconditionally. Gaps (in_valid=0) mid-frame are allowed and do not disturb acc.
- Single-beat frames (in_last=1 every beat) give a plain pipelined tree.

## Timing
- Reset values: out_valid=0, out_sum=0, first=1, all pipeline valid/last bits 0. Tree data registers need not be reset.
- Latency: beat with in_last at cycle t → out_valid at cycle t+S+1.
- Throughput: one beat per cycle; back-to-back frames produce out_valid on consecutive cycles when every beat is last.
- First beat of a new frame can arrive the cycle after a last beat; first flag guarantees no carry-over.
- Reset asserted mid-frame: partial sum and all in-flight beats are discarded; no out_valid is produced for them after release.
- in_valid=0 with in_last=1: no effect.

## Structure
- Package adder_tree_pkg: functions tree_levels(length), stage_count(levels, levels_per_stage), level_length(length, level) for sizing generate loops.
- Sub-module adder_tree_level: one combinational reduction level, parameters IN_LENGTH and IN_WIDTH, output ceil(IN_LENGTH/2) elements of IN_WIDTH+1. Top instantiates LEVELS of them via generate and inserts registers every LEVELS_PER_STAGE levels.
- Accumulator, first flag and output registers live in the top.

## Test plan
- Defaults, single beat of 42×(+1) with in_last → out_valid at t+4 (S=3), out_sum=42.
- Single beat of 42×(−128) → out_sum=−5376; 42×(+127) → 5334 (extreme tree widths).
- Frame of 3 beats: all 1, all 2, all −1, with an idle cycle between beats 2 and 3 → single out_valid, out_sum=84; out_sum holds afterward.
- Back-to-back single-beat frames with sums 10, −20, 30 on consecutive cycles → out_valid high three consecutive cycles, values 10, −20, 30, no carry-over.
- ACC_GUARD=0, LENGTH=2, DATA_WIDTH=8: frame of two beats each {127,127} → 508 wraps to −4 (OUT_WIDTH=9).
- Reset pulsed after 2 beats of a 4-beat frame, then a fresh 1-beat frame of all 1 → no stray out_valid; out_sum=42.
- LENGTH=1, LEVELS_PER_STAGE=1: beat 5 with in_last → out_valid at t+2, out_sum=5.
